// File: rtl/edge_pkg.sv
// Shared definitions for the pixel I/O engine: FSM state encoding and the
// default burst depths for the read and write payload buffers.
package edge_pkg;

  // Transaction phases of the engine.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } io_state_t;

  // Depth of the read_data buffer (bytes per read burst).
  localparam int READ_BLOCK_MAX  = 20;
  // Depth of the write_data buffer (bytes per write burst).
  localparam int WRITE_BLOCK_MAX = 10;

endpackage : edge_pkg

// File: rtl/pixel_io_engine.sv
// pixel_io_engine: runs one transaction per accepted start: a read burst of up
// to READ_MAX bytes into read_data, then a write burst of up to WRITE_MAX bytes
// from write_data, then a one-cycle io_final pulse.
//
// Memory handshake: a request (mem_read or mem_write with mem_addr/mem_wdata)
// is presented by the engine and held unchanged until a cycle in which
// mem_ready=1; that cycle is the transfer. mem_read and mem_write are never
// high together.
//
// Build option: define PIXEL_IO_ZERO_FILL_EN to clear all of read_data when a
// transaction is accepted; otherwise unread bytes keep their old values.
module pixel_io_engine
  import edge_pkg::*;
#(
  parameter int READ_MAX  = READ_BLOCK_MAX,
  parameter int WRITE_MAX = WRITE_BLOCK_MAX
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic [31:0]                read_start_address,
  input  logic [4:0]                 read_length,
  input  logic [31:0]                write_start_address,
  input  logic [4:0]                 write_length,
  input  logic [WRITE_MAX-1:0][7:0]  write_data,
  output logic [READ_MAX-1:0][7:0]   read_data,
  output logic                       io_final,
  output logic                       busy,
  output logic [31:0]                mem_addr,
  output logic [7:0]                 mem_wdata,
  output logic                       mem_read,
  output logic                       mem_write,
  input  logic [7:0]                 mem_rdata,
  input  logic                       mem_ready,
  output io_state_t                  dbg_state
);

  // Registered state.
  io_state_t                state_q, state_d;
  logic [4:0]               idx_q, idx_d;       // shared beat index for both phases
  logic [31:0]              rd_base_q, rd_base_d;
  logic [31:0]              wr_base_q, wr_base_d;
  logic [4:0]               rd_len_q, rd_len_d;
  logic [4:0]               wr_len_q, wr_len_d;
  logic [READ_MAX-1:0][7:0] read_data_q, read_data_d;

  // Requested lengths limited to the buffer depths.
  logic [4:0] rd_clamp;
  logic [4:0] wr_clamp;
  // Write byte selected by the current beat index.
  logic [7:0] wr_byte;
  // Index of the beat following the current one.
  logic [4:0] idx_inc;

  assign idx_inc = idx_q + 5'd1;

  // Clamp incoming lengths against the buffer depths.
  always_comb begin
    rd_clamp = (read_length  > 5'(READ_MAX))  ? 5'(READ_MAX)  : read_length;
    wr_clamp = (write_length > 5'(WRITE_MAX)) ? 5'(WRITE_MAX) : write_length;
  end

  // Select the live write payload byte for the current beat.
  always_comb begin
    wr_byte = 8'h00;
    for (int i = 0; i < WRITE_MAX; i++) begin
      if (idx_q == 5'(i)) wr_byte = write_data[i];
    end
  end

  // Next-state, datapath updates and memory request outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_base_d   = rd_base_q;
    wr_base_d   = wr_base_q;
    rd_len_d    = rd_len_q;
    wr_len_d    = wr_len_q;
    read_data_d = read_data_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = 32'h0;
    mem_wdata   = 8'h00;

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_base_d = read_start_address;
          wr_base_d = write_start_address;
          rd_len_d  = rd_clamp;
          wr_len_d  = wr_clamp;
          idx_d     = 5'd0;
`ifdef PIXEL_IO_ZERO_FILL_EN
          read_data_d = '0;
`else
          read_data_d = read_data_q;
`endif
          if (rd_clamp != 5'd0)      state_d = READ;
          else if (wr_clamp != 5'd0) state_d = WRITE;
          else                       state_d = DONE;
        end
      end

      READ: begin
        mem_read = 1'b1;
        mem_addr = rd_base_q + {27'd0, idx_q};
        if (mem_ready) begin
          for (int i = 0; i < READ_MAX; i++) begin
            if (idx_q == 5'(i)) read_data_d[i] = mem_rdata;
          end
          if (idx_inc == rd_len_q) begin
            idx_d   = 5'd0;
            state_d = (wr_len_q != 5'd0) ? WRITE : DONE;
          end else begin
            idx_d = idx_inc;
          end
        end
      end

      WRITE: begin
        mem_write = 1'b1;
        mem_addr  = wr_base_q + {27'd0, idx_q};
        mem_wdata = wr_byte;
        if (mem_ready) begin
          if (idx_inc == wr_len_q) begin
            idx_d   = 5'd0;
            state_d = DONE;
          end else begin
            idx_d = idx_inc;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      idx_q       <= 5'd0;
      rd_base_q   <= 32'h0;
      wr_base_q   <= 32'h0;
      rd_len_q    <= 5'd0;
      wr_len_q    <= 5'd0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_base_q   <= rd_base_d;
      wr_base_q   <= wr_base_d;
      rd_len_q    <= rd_len_d;
      wr_len_q    <= wr_len_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;
  assign io_final  = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule : pixel_io_engine

// File: tb/tb_pixel_io_engine.sv
// Testbench for pixel_io_engine: transaction-level reference model feeding an
// expected queue, a memory responder, and a monitor comparing every transfer
// and every completion against the queue.
module tb_pixel_io_engine;
  import edge_pkg::*;

  localparam int RMAX   = 20;
  localparam int WMAX   = 10;
  localparam int BUDGET = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                  start;
  logic [31:0]           read_start_address;
  logic [4:0]            read_length;
  logic [31:0]           write_start_address;
  logic [4:0]            write_length;
  logic [WMAX-1:0][7:0]  write_data;
  logic [RMAX-1:0][7:0]  read_data;
  logic                  io_final;
  logic                  busy;
  logic [31:0]           mem_addr;
  logic [7:0]            mem_wdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [7:0]            mem_rdata;
  logic                  mem_ready = 1'b0;
  io_state_t             dbg_state;

  pixel_io_engine #(.READ_MAX(RMAX), .WRITE_MAX(WMAX)) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .start               (start),
    .read_start_address  (read_start_address),
    .read_length         (read_length),
    .write_start_address (write_start_address),
    .write_length        (write_length),
    .write_data          (write_data),
    .read_data           (read_data),
    .io_final            (io_final),
    .busy                (busy),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .mem_rdata           (mem_rdata),
    .mem_ready           (mem_ready),
    .dbg_state           (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  // {write, read, addr, data}; data is 0 for reads
  logic [41:0]            exp_q[$];
  logic [RMAX*8-1:0]      exp_rd_q[$];
  logic [RMAX-1:0][7:0]   model_rd;
  int                     ready_mode = 0;   // 0: always ready, 1: random, 2: two wait cycles per beat

  task automatic report(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory contents: a fixed function of the address, with a few seeded bytes.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'hAA;
      32'h0000_0101: return 8'hBB;
      32'h0000_0102: return 8'hCC;
      default:       return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
    endcase
  endfunction

  assign mem_rdata = mem_byte(mem_addr);

  // ---------------- memory ready responder ----------------
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = 1'($urandom_range(0, 1));
        default: begin
          if (mem_read || mem_write) begin
            if (wait_cnt < 2) begin
              mem_ready = 1'b0;
              wait_cnt++;
            end else begin
              mem_ready = 1'b1;
              wait_cnt  = 0;
            end
          end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
          end
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic [41:0] prev_req;
  bit          prev_pend = 1'b0;

  always @(negedge clk) begin
    logic [41:0] act;
    logic [41:0] e;
    if (!n_rst) begin
      prev_pend = 1'b0;
    end else begin
      act = {mem_write, mem_read, mem_addr, (mem_write ? mem_wdata : 8'h00)};
      if (mem_read || mem_write)
        report("req_exclusive", 160'(mem_read & mem_write), 160'(0));
      if (prev_pend)
        report("req_hold", 160'(act), 160'(prev_req));
      if (mem_read || mem_write) begin
        prev_pend = !mem_ready;
        prev_req  = act;
      end else begin
        prev_pend = 1'b0;
      end
      if ((mem_read || mem_write) && mem_ready) begin
        if (exp_q.size() == 0) begin
          report("unexpected_transfer", 160'(act), 160'(0));
        end else begin
          e = exp_q.pop_front();
          report("transfer", 160'(act), 160'(e));
        end
      end
      if (io_final) begin
        if (exp_rd_q.size() == 0)
          report("unexpected_io_final", 160'(1), 160'(0));
        else
          report("read_data", 160'(read_data), 160'(exp_rd_q.pop_front()));
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_txn(input logic [31:0] rb, input logic [4:0] rl,
                          input logic [31:0] wb, input logic [4:0] wl,
                          input logic [WMAX-1:0][7:0] wd,
                          output int n, output int m);
    n = (int'(rl) > RMAX) ? RMAX : int'(rl);
    m = (int'(wl) > WMAX) ? WMAX : int'(wl);
`ifdef PIXEL_IO_ZERO_FILL_EN
    model_rd = '0;
`endif
    for (int i = 0; i < n; i++) begin
      model_rd[i] = mem_byte(rb + 32'(i));
      exp_q.push_back({2'b01, rb + 32'(i), 8'h00});
    end
    for (int j = 0; j < m; j++)
      exp_q.push_back({2'b10, wb + 32'(j), wd[j]});
    exp_rd_q.push_back(model_rd);
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs(input logic [31:0] rb, input logic [4:0] rl,
                              input logic [31:0] wb, input logic [4:0] wl,
                              input logic [WMAX-1:0][7:0] wd);
    read_start_address  = rb;
    read_length         = rl;
    write_start_address = wb;
    write_length        = wl;
    write_data          = wd;
  endtask

  // lat: -1 no latency check, 0 expect n+m+1, otherwise the given cycle.
  task automatic run_txn(input logic [31:0] rb, input logic [4:0] rl,
                         input logic [31:0] wb, input logic [4:0] wl,
                         input logic [WMAX-1:0][7:0] wd, input int lat);
    int n, m, cyc, want;
    push_txn(rb, rl, wb, wl, wd, n, m);
    drive_inputs(rb, rl, wb, wl, wd);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!io_final && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!io_final) begin
      report("io_final_timeout", 160'(0), 160'(1));
    end else if (lat >= 0) begin
      want = (lat == 0) ? (n + m + 1) : lat;
      report("latency", 160'(cyc), 160'(want));
    end
    @(posedge clk); #1;
    report("idle_after_done", 160'(busy), 160'(0));
  endtask

  task automatic check_outputs_zero(input string name);
    report(name, 160'({mem_read, mem_write, mem_addr, mem_wdata, io_final, busy}), 160'(0));
    report({name, "_read_data"}, 160'(read_data), 160'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WMAX-1:0][7:0] wd;
    int n, m, cyc;
    start = 1'b0;
    drive_inputs(32'h0, 5'd0, 32'h0, 5'd0, '0);
    model_rd = '0;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_outputs");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Read three seeded bytes, no write.
    ready_mode = 0;
    run_txn(32'h100, 5'd3, 32'h0, 5'd0, '0, 4);
    report("seeded_bytes", 160'({read_data[2], read_data[1], read_data[0]}), 160'(24'hCCBBAA));

    // Write two bytes, no read.
    wd = '0; wd[0] = 8'h11; wd[1] = 8'h22;
    run_txn(32'h0, 5'd0, 32'h200, 5'd2, wd, 3);

    // Oversized lengths clamp to the buffer depths.
    for (int i = 0; i < WMAX; i++) wd[i] = 8'($urandom);
    run_txn(32'h1000, 5'd25, 32'h2000, 5'd12, wd, 31);

    // Two wait cycles per beat.
    ready_mode = 2;
    wd[0] = 8'h5E;
    run_txn(32'h40, 5'd1, 32'h80, 5'd1, wd, 7);
    ready_mode = 0;

    // Address wrap past 2^32.
    run_txn(32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFF, 5'd3, wd, 0);

    // Both lengths zero; start held high through DONE must be ignored.
    push_txn(32'h0, 5'd0, 32'h0, 5'd0, wd, n, m);
    drive_inputs(32'h0, 5'd0, 32'h0, 5'd0, wd);
    start = 1'b1;
    @(posedge clk); #1;
    report("zero_len_final", 160'(io_final), 160'(1));
    @(posedge clk); #1;
    start = 1'b0;
    report("start_ignored_in_done", 160'(busy), 160'(0));
    repeat (3) @(posedge clk);
    #1;
    report("still_idle", 160'(busy), 160'(0));

    // Reset during the second read beat of five.
    push_txn(32'h300, 5'd5, 32'h400, 5'd3, wd, n, m);
    drive_inputs(32'h300, 5'd5, 32'h400, 5'd3, wd);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    report("beat2_addr", 160'(mem_addr), 160'(32'h301));
    n_rst = 1'b0;
    #1;
    check_outputs_zero("mid_reset_outputs");
    exp_q.delete();
    exp_rd_q.delete();
    model_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    report("no_final_after_abort", 160'(busy), 160'(0));
    run_txn(32'h300, 5'd5, 32'h400, 5'd3, wd, 0);

    // Randomized transactions.
    for (int t = 0; t < 16; t++) begin
      ready_mode = int'($urandom_range(0, 1));
      for (int i = 0; i < WMAX; i++) wd[i] = 8'($urandom);
      run_txn(32'($urandom), 5'($urandom_range(0, 31)), 32'($urandom),
              5'($urandom_range(0, 31)), wd, (ready_mode == 0) ? 0 : -1);
    end

    repeat (3) @(posedge clk);
    #1;
    report("exp_q_drained", 160'(exp_q.size()), 160'(0));
    report("exp_rd_q_drained", 160'(exp_rd_q.size()), 160'(0));
    cyc = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pixel_io_engine
